// File: rtl/trigger_sequencer.sv
// Trigger sequencer: gates capture windows from edge-detector trigger pulses
// with an arm/delay/window/holdoff sequence, and keeps accepted/missed trigger stats.
module trigger_sequencer #(
  parameter int unsigned CNT_WIDTH  = 16,
  parameter int unsigned STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trig_in,
  input  logic                  arm,
  input  logic                  abort,
  input  logic                  auto_rearm,
  input  logic [CNT_WIDTH-1:0]  delay_len,
  input  logic [CNT_WIDTH-1:0]  window_len,
  input  logic [CNT_WIDTH-1:0]  holdoff_len,
  output logic                  armed,
  output logic                  busy,
  output logic                  capture_en,
  output logic                  done,
  output logic [STAT_WIDTH-1:0] trig_count,
  output logic [STAT_WIDTH-1:0] missed_count
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ARMED   = 3'd1,
    S_DELAY   = 3'd2,
    S_WINDOW  = 3'd3,
    S_HOLDOFF = 3'd4
  } state_e;

  state_e                state_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [CNT_WIDTH-1:0]  win_q;
  logic [CNT_WIDTH-1:0]  hold_q;
  logic [CNT_WIDTH-1:0]  win_eff_c;
  logic                  armed_q;
  logic                  busy_q;
  logic                  capture_q;
  logic                  done_q;
  logic [STAT_WIDTH-1:0] trig_q;
  logic [STAT_WIDTH-1:0] trig_d;
  logic [STAT_WIDTH-1:0] missed_q;
  logic [STAT_WIDTH-1:0] missed_d;
  logic                  accept_c;
  logic                  miss_c;

  // Trigger classification and saturating statistics; abort suppresses both counts.
  always_comb begin
    accept_c  = !abort && trig_in && (state_q == S_ARMED);
    miss_c    = !abort && trig_in && (state_q != S_ARMED);
    win_eff_c = (window_len == '0) ? CNT_WIDTH'(1) : window_len;
    trig_d    = trig_q;
    missed_d  = missed_q;
    if (accept_c && (trig_q != '1)) begin
      trig_d = trig_q + STAT_WIDTH'(1);
    end
    if (miss_c && (missed_q != '1)) begin
      missed_d = missed_q + STAT_WIDTH'(1);
    end
  end

  // Sequencer FSM; outputs are registered alongside the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      win_q     <= '0;
      hold_q    <= '0;
      armed_q   <= 1'b0;
      busy_q    <= 1'b0;
      capture_q <= 1'b0;
      done_q    <= 1'b0;
      trig_q    <= '0;
      missed_q  <= '0;
    end else begin
      trig_q   <= trig_d;
      missed_q <= missed_d;
      done_q   <= 1'b0;
      if (abort) begin
        state_q   <= S_IDLE;
        armed_q   <= 1'b0;
        busy_q    <= 1'b0;
        capture_q <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (arm) begin
              state_q <= S_ARMED;
              armed_q <= 1'b1;
            end
          end
          S_ARMED: begin
            if (trig_in) begin
              win_q   <= win_eff_c;
              hold_q  <= holdoff_len;
              armed_q <= 1'b0;
              busy_q  <= 1'b1;
              if (delay_len != '0) begin
                state_q <= S_DELAY;
                cnt_q   <= delay_len;
              end else begin
                state_q   <= S_WINDOW;
                cnt_q     <= win_eff_c;
                capture_q <= 1'b1;
              end
            end
          end
          S_DELAY: begin
            if (cnt_q == CNT_WIDTH'(1)) begin
              state_q   <= S_WINDOW;
              cnt_q     <= win_q;
              capture_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
          end
          S_WINDOW: begin
            if (cnt_q == CNT_WIDTH'(1)) begin
              capture_q <= 1'b0;
              done_q    <= 1'b1;
              if (hold_q != '0) begin
                state_q <= S_HOLDOFF;
                cnt_q   <= hold_q;
              end else begin
                state_q <= auto_rearm ? S_ARMED : S_IDLE;
                armed_q <= auto_rearm;
                busy_q  <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
          end
          S_HOLDOFF: begin
            if (cnt_q == CNT_WIDTH'(1)) begin
              state_q <= auto_rearm ? S_ARMED : S_IDLE;
              armed_q <= auto_rearm;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CNT_WIDTH'(1);
            end
          end
          default: begin
            state_q   <= S_IDLE;
            armed_q   <= 1'b0;
            busy_q    <= 1'b0;
            capture_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign armed        = armed_q;
  assign busy         = busy_q;
  assign capture_en   = capture_q;
  assign done         = done_q;
  assign trig_count   = trig_q;
  assign missed_count = missed_q;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Self-checking bench for trigger_sequencer: directed scenarios plus random
// stimulus compared against a timestamp-based model of the capture schedule.
module tb_trigger_sequencer;

  localparam int unsigned CW = 16;
  localparam int unsigned SW = 16;
  localparam longint      SMAX = 65535;

  logic          clk;
  logic          r_rst, r_trig, r_arm, r_abort, r_ar;
  logic [CW-1:0] r_dly, r_win, r_hold;
  logic          armed, busy, capture_en, done;
  logic [SW-1:0] trig_count, missed_count;
  logic [35:0]   obs;

  int checks = 0;
  int errors = 0;

  // Model: mode 0 idle, 1 armed, 2 running; schedule held as absolute cycle numbers.
  longint m_n = 0;
  int     m_mode = 0;
  longint m_trig = 0, m_miss = 0;
  longint m_ws = 0, m_we = 0, m_he = 0, m_done_at = -1;

  trigger_sequencer #(.CNT_WIDTH(CW), .STAT_WIDTH(SW)) dut (
    .clk(clk), .rst(r_rst), .trig_in(r_trig), .arm(r_arm), .abort(r_abort),
    .auto_rearm(r_ar), .delay_len(r_dly), .window_len(r_win), .holdoff_len(r_hold),
    .armed(armed), .busy(busy), .capture_en(capture_en), .done(done),
    .trig_count(trig_count), .missed_count(missed_count)
  );

  assign obs = {armed, busy, capture_en, done, trig_count, missed_count};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [35:0] exp_vec();
    logic cap;
    cap = (m_mode == 2) && (m_n >= m_ws) && (m_n <= m_we);
    return {m_mode == 1, m_mode == 2, cap, m_n == m_done_at, SW'(m_trig), SW'(m_miss)};
  endfunction

  task automatic model_update();
    longint p;
    longint w;
    p = m_n;
    m_n++;
    if (r_rst) begin
      m_mode = 0; m_trig = 0; m_miss = 0; m_done_at = -1;
    end else begin
      if (!r_abort && r_trig) begin
        if (m_mode == 1) begin
          if (m_trig < SMAX) m_trig++;
        end else if (m_miss < SMAX) m_miss++;
      end
      if (r_abort) begin
        m_mode = 0; m_done_at = -1;
      end else begin
        case (m_mode)
          0: if (r_arm) m_mode = 1;
          1: if (r_trig) begin
            w = (r_win == 0) ? 1 : longint'(r_win);
            m_ws = p + 1 + longint'(r_dly);
            m_we = m_ws + w - 1;
            m_he = m_we + longint'(r_hold);
            m_done_at = m_we + 1;
            m_mode = 2;
          end
          default: if (p == m_he) m_mode = r_ar ? 1 : 0;
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
    r_arm = 1'b0; r_abort = 1'b0; r_trig = 1'b0;
  endtask

  task automatic test_reset();
    r_rst = 1'b1;
    tick(); tick();
    checks++;
    if (obs !== 36'd0) begin
      errors++; $display("FAIL reset_zero got=%h exp=%h", obs, 36'd0);
    end
    checks++;
    if (obs !== exp_vec()) begin
      errors++; $display("FAIL reset_model got=%h exp=%h", obs, exp_vec());
    end
    r_rst = 1'b0;
  endtask

  task automatic test_single_window();
    int caps = 0;
    r_dly = 0; r_win = 4; r_hold = 0; r_ar = 0;
    r_arm = 1; tick();
    r_trig = 1; tick();
    for (int i = 0; i < 8; i++) begin
      caps += int'(capture_en);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL single_window cyc=%0d got=%h exp=%h", m_n, obs, exp_vec());
      end
      tick();
    end
    checks++;
    if (caps != 4 || trig_count !== 16'd1) begin
      errors++; $display("FAIL single_window_len caps=%0d trig=%0d exp caps=4 trig=1", caps, trig_count);
    end
  endtask

  task automatic test_holdoff_rearm();
    int caps = 0;
    r_dly = 3; r_win = 2; r_hold = 5; r_ar = 1;
    r_arm = 1; tick();
    r_trig = 1; tick();
    for (int i = 1; i <= 14; i++) begin
      if (i == 8) r_trig = 1;
      caps += int'(capture_en);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL holdoff_rearm cyc=%0d got=%h exp=%h", m_n, obs, exp_vec());
      end
      tick();
    end
    checks++;
    if (caps != 2 || armed !== 1'b1) begin
      errors++; $display("FAIL holdoff_rearm_end caps=%0d armed=%b exp caps=2 armed=1", caps, armed);
    end
    r_ar = 0; r_abort = 1; tick();
  endtask

  task automatic test_zero_window();
    int caps = 0;
    r_dly = 1; r_win = 0; r_hold = 0; r_ar = 0;
    r_arm = 1; tick();
    r_trig = 1; tick();
    for (int i = 0; i < 6; i++) begin
      caps += int'(capture_en);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL zero_window cyc=%0d got=%h exp=%h", m_n, obs, exp_vec());
      end
      tick();
    end
    checks++;
    if (caps != 1) begin
      errors++; $display("FAIL zero_window_len got=%0d exp=1", caps);
    end
    caps = 0;
    r_dly = 0; r_win = 3;
    r_arm = 1; tick();
    r_trig = 1; tick();
    for (int i = 0; i < 7; i++) begin
      if (i == 1) r_win = 9;
      caps += int'(capture_en);
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL cfg_change cyc=%0d got=%h exp=%h", m_n, obs, exp_vec());
      end
      tick();
    end
    checks++;
    if (caps != 3) begin
      errors++; $display("FAIL cfg_change_len got=%0d exp=3", caps);
    end
  endtask

  task automatic test_abort();
    r_dly = 0; r_win = 6; r_hold = 2; r_ar = 1;
    r_arm = 1; tick();
    r_trig = 1; tick();
    tick(); tick();
    r_abort = 1; tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (obs !== exp_vec() || capture_en !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL abort cyc=%0d got=%h exp=%h", m_n, obs, exp_vec());
      end
      tick();
    end
    r_ar = 0; r_win = 2; r_hold = 0;
    r_arm = 1; r_abort = 1; tick();
    checks++;
    if (armed !== 1'b0) begin
      errors++; $display("FAIL abort_arm got=%b exp=0", armed);
    end
    r_arm = 1; tick();
    r_trig = 1; tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL abort_resume cyc=%0d got=%h exp=%h", m_n, obs, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    longint trig_before;
    trig_before = m_trig;
    @(negedge clk);
    force dut.missed_q = 16'hFFFE;
    #1;
    release dut.missed_q;
    m_miss = 16'hFFFE;
    for (int i = 0; i < 3; i++) begin
      r_trig = 1; tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL saturation cyc=%0d got=%h exp=%h", m_n, obs, exp_vec());
      end
    end
    checks++;
    if (missed_count !== 16'hFFFF || trig_count !== SW'(trig_before)) begin
      errors++; $display("FAIL saturation_end missed=%h trig=%0d exp missed=ffff trig=%0d",
                         missed_count, trig_count, trig_before);
    end
  endtask

  task automatic test_reset_mid_delay();
    r_dly = 5; r_win = 3; r_hold = 0; r_ar = 0;
    r_arm = 1; tick();
    r_trig = 1; tick();
    tick();
    r_rst = 1; r_trig = 1; tick();
    checks++;
    if (obs !== 36'd0 || obs !== exp_vec()) begin
      errors++; $display("FAIL reset_mid_delay got=%h exp=%h", obs, 36'd0);
    end
    r_rst = 0;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL reset_after cyc=%0d got=%h exp=%h", m_n, obs, exp_vec());
      end
      tick();
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      r_rst   = ($urandom_range(0, 199) == 0);
      r_abort = ($urandom_range(0, 39) == 0);
      r_arm   = ($urandom_range(0, 3) == 0);
      r_trig  = ($urandom_range(0, 3) == 0);
      r_ar    = ($urandom_range(0, 1) == 1);
      r_dly   = CW'($urandom_range(0, 5));
      r_win   = CW'($urandom_range(0, 5));
      r_hold  = CW'($urandom_range(0, 5));
      tick();
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random cyc=%0d got=%h exp=%h", m_n, obs, exp_vec());
      end
    end
  endtask

  initial begin
    r_rst = 1; r_trig = 0; r_arm = 0; r_abort = 0; r_ar = 0;
    r_dly = '0; r_win = '0; r_hold = '0;
    test_reset();
    test_single_window();
    test_holdoff_rearm();
    test_zero_window();
    test_abort();
    test_saturation();
    test_reset_mid_delay();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
